nav_button_conditioner: RTL and testbench

- Front-end source of the navigation strobes consumed by the filter-select screen (its left/right inputs) and a confirm strobe for the filter pipeline.
- Takes raw, asynchronous board buttons (left, right, select). Synchronises, debounces, and emits clean single-cycle pulses.
- Left/right support hold-to-auto-repeat so the user can cycle through the six filter slots.
- Sits between the top-level button pins and the UI/filter-control blocks, in the pixel clock domain.

---
 rtl/ui_pkg.sv | 28 ++
 rtl/button_debouncer.sv | 54 +++++
 rtl/nav_button_conditioner.sv | 147 ++++++++++++++
 tb/tb_nav_button_conditioner.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ui_pkg.sv
// Shared UI definitions: nav FSM states, direction encoding, 74.25 MHz timing defaults.
// Also holds a width helper so every counter is sized from its governing parameter.
package ui_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        REPEAT  = 2'd2,
        LOCKOUT = 2'd3
    } nav_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int unsigned DEF_DEBOUNCE_CYCLES     = 742_500;
    localparam int unsigned DEF_REPEAT_DELAY_CYCLES = 37_125_000;
    localparam int unsigned DEF_REPEAT_RATE_CYCLES  = 7_425_000;

    // Width able to hold n-1; at least one bit so degenerate settings still elaborate.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// 2-flop synchroniser plus stable-level debouncer for one raw button.
// Raw-to-level latency is 2 + DEBOUNCE_CYCLES clocks; shorter glitches are discarded.
module button_debouncer
    import ui_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic raw_in,
    output logic level_out
);

    localparam int unsigned     CW     = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter only runs while the synced input disagrees; terminal count flips and clears it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_TC) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_out = level_q;

endmodule

// File: rtl/nav_button_conditioner.sv
// Turns raw left/right/select buttons into clean single-cycle nav/confirm pulses with hold-to-repeat.
// First nav pulse one clock after the debounced rise; repeats after REPEAT_DELAY, then every REPEAT_RATE.
module nav_button_conditioner
    import ui_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
    parameter int unsigned REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       btn_left_in,
    input  logic       btn_right_in,
    input  logic       btn_select_in,
    output logic       left_out,
    output logic       right_out,
    output logic       select_out,
    output logic [1:0] held_out
);

    localparam int unsigned   TW       = cnt_width(max2(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES));
    localparam logic [TW-1:0] DELAY_TC = TW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TW-1:0] RATE_TC  = TW'(REPEAT_RATE_CYCLES - 1);

    logic lvl_l;
    logic lvl_r;
    logic lvl_s;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .raw_in    (btn_left_in),
        .level_out (lvl_l)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .raw_in    (btn_right_in),
        .level_out (lvl_r)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_select (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .raw_in    (btn_select_in),
        .level_out (lvl_s)
    );

    nav_state_t    state_q;
    nav_state_t    state_d;
    logic          dir_q;
    logic          dir_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          left_q;
    logic          left_d;
    logic          right_q;
    logic          right_d;
    logic          sel_prev_q;
    logic          select_q;

    logic          dir_lvl;
    logic          oth_lvl;
    logic [TW-1:0] timer_tc;

    assign dir_lvl  = (dir_q == DIR_RIGHT) ? lvl_r : lvl_l;
    assign oth_lvl  = (dir_q == DIR_RIGHT) ? lvl_l : lvl_r;
    assign timer_tc = (state_q == DELAY) ? DELAY_TC : RATE_TC;

    // Release beats lockout beats terminal count, so a chord can never leak a pulse.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        left_d  = 1'b0;
        right_d = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (lvl_l && lvl_r) begin
                    state_d = LOCKOUT;
                end else if (lvl_l) begin
                    left_d  = 1'b1;
                    dir_d   = DIR_LEFT;
                    state_d = DELAY;
                end else if (lvl_r) begin
                    right_d = 1'b1;
                    dir_d   = DIR_RIGHT;
                    state_d = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (!dir_lvl) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (oth_lvl) begin
                    state_d = LOCKOUT;
                    timer_d = '0;
                end else if (timer_q == timer_tc) begin
                    left_d  = (dir_q == DIR_LEFT);
                    right_d = (dir_q == DIR_RIGHT);
                    timer_d = '0;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            LOCKOUT: begin
                timer_d = '0;
                if (!lvl_l && !lvl_r) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            dir_q      <= DIR_LEFT;
            timer_q    <= '0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            sel_prev_q <= 1'b0;
            select_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            timer_q    <= timer_d;
            left_q     <= left_d;
            right_q    <= right_d;
            sel_prev_q <= lvl_s;
            select_q   <= lvl_s & ~sel_prev_q;
        end
    end

    assign left_out   = left_q;
    assign right_out  = right_q;
    assign select_out = select_q;
    assign held_out   = {lvl_r, lvl_l};

endmodule

// File: tb/tb_nav_button_conditioner.sv
// Directed bench: expected pulses (cycle, kind) are queued as stimulus is driven and popped as the DUT pulses.
// Debounced rise lands 6 clocks after a raw change driven between edges; the first nav pulse one clock later.
module tb_nav_button_conditioner;

    localparam int K_LEFT  = 0;
    localparam int K_RIGHT = 1;
    localparam int K_SEL   = 2;

    logic       clk_in        = 1'b0;
    logic       rst_in        = 1'b1;
    logic       btn_left_in   = 1'b0;
    logic       btn_right_in  = 1'b0;
    logic       btn_select_in = 1'b0;
    logic       left_out;
    logic       right_out;
    logic       select_out;
    logic [1:0] held_out;

    typedef struct {
        int cyc;
        int kind;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    nav_button_conditioner #(
        .DEBOUNCE_CYCLES     (4),
        .REPEAT_DELAY_CYCLES (20),
        .REPEAT_RATE_CYCLES  (5)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .btn_left_in   (btn_left_in),
        .btn_right_in  (btn_right_in),
        .btn_select_in (btn_select_in),
        .left_out      (left_out),
        .right_out     (right_out),
        .select_out    (select_out),
        .held_out      (held_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic observe(input logic v, input int kind);
        exp_t e;
        if (v) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL pulse_unexpected: kind=%0d at cycle %0d, required no pulse", kind, cyc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                assert (e.cyc === cyc && e.kind === kind) else begin
                    errors++;
                    $error("FAIL pulse_timing: got kind=%0d cycle=%0d, required kind=%0d cycle=%0d",
                           kind, cyc, e.kind, e.cyc);
                end
            end
        end
    endtask

    always @(negedge clk_in) begin
        checks++;
        assert (!(left_out && right_out)) else begin
            errors++;
            $error("FAIL lr_exclusive: left=%0b right=%0b at cycle %0d, required not both", left_out, right_out, cyc);
        end
        observe(left_out, K_LEFT);
        observe(right_out, K_RIGHT);
        observe(select_out, K_SEL);
    end

    task automatic push(input int c, input int kind);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk_in);
    endtask

    task automatic check_held(input logic [1:0] exp, input string tag);
        checks++;
        assert (held_out === exp) else begin
            errors++;
            $error("FAIL %s: held_out=%b, required %b", tag, held_out, exp);
        end
    endtask

    task automatic check_drained(input string tag);
        checks++;
        assert (exp_q.size() === 0) else begin
            errors++;
            $error("FAIL %s: %0d expected pulses missing, required 0", tag, exp_q.size());
        end
    endtask

    initial begin
        int n;
        int t0;
        int r;

        // Reset state
        repeat (3) @(negedge clk_in);
        checks++;
        assert ({left_out, right_out, select_out, held_out} === 5'b0) else begin
            errors++;
            $error("FAIL reset_state: outputs=%b, required 00000", {left_out, right_out, select_out, held_out});
        end
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);

        // Short left glitch, then a right bouncing every 2 cycles: nothing may get through
        n = cyc;
        btn_left_in = 1'b1;
        at_cycle(n + 3);
        btn_left_in = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) btn_right_in = ~btn_right_in;
            @(negedge clk_in);
            check_held(2'b00, "bounce_held");
        end
        btn_right_in = 1'b0;
        repeat (10) @(negedge clk_in);
        check_drained("bounce_drain");

        // Right held: pulses at t0+1, t0+21, then every 5 up to t0+56; debounced release at t0+60
        @(negedge clk_in);
        n = cyc;
        btn_right_in = 1'b1;
        t0 = n + 6;
        push(t0 + 1, K_RIGHT);
        push(t0 + 21, K_RIGHT);
        for (int k = 26; k <= 56; k += 5) push(t0 + k, K_RIGHT);
        at_cycle(t0 - 1);
        check_held(2'b00, "right_pre_debounce");
        at_cycle(t0);
        check_held(2'b10, "right_debounced");
        at_cycle(t0 + 54);
        btn_right_in = 1'b0;
        at_cycle(t0 + 75);
        check_drained("repeat_drain");
        check_held(2'b00, "repeat_released");

        // Left repeating, then right joins: last pulse at t0+31, nothing after debounced right at t0+33
        n = cyc;
        btn_left_in = 1'b1;
        t0 = n + 6;
        push(t0 + 1, K_LEFT);
        push(t0 + 21, K_LEFT);
        push(t0 + 26, K_LEFT);
        push(t0 + 31, K_LEFT);
        at_cycle(t0 + 27);
        btn_right_in = 1'b1;
        at_cycle(t0 + 33);
        check_held(2'b11, "chord_held");
        at_cycle(t0 + 50);
        btn_right_in = 1'b0;
        at_cycle(t0 + 70);
        check_held(2'b01, "lockout_left_only");
        check_drained("lockout_drain");
        btn_left_in = 1'b0;
        at_cycle(t0 + 80);
        check_held(2'b00, "lockout_released");
        n = cyc;
        btn_left_in = 1'b1;
        push(n + 7, K_LEFT);
        at_cycle(n + 10);
        btn_left_in = 1'b0;
        at_cycle(n + 25);
        check_drained("fresh_left_drain");

        // Simultaneous press goes straight to lockout; a later single press still works
        n = cyc;
        btn_left_in  = 1'b1;
        btn_right_in = 1'b1;
        at_cycle(n + 6);
        check_held(2'b11, "both_held");
        at_cycle(n + 36);
        btn_left_in  = 1'b0;
        btn_right_in = 1'b0;
        at_cycle(n + 46);
        check_held(2'b00, "both_released");
        check_drained("both_drain");
        n = cyc;
        btn_right_in = 1'b1;
        push(n + 7, K_RIGHT);
        at_cycle(n + 10);
        btn_right_in = 1'b0;
        at_cycle(n + 22);
        check_drained("after_lockout_drain");

        // Select held 100 cycles: a single pulse 7 cycles after the raw rise
        n = cyc;
        btn_select_in = 1'b1;
        push(n + 7, K_SEL);
        at_cycle(n + 20);
        check_held(2'b00, "select_not_nav");
        at_cycle(n + 100);
        btn_select_in = 1'b0;
        at_cycle(n + 112);
        check_drained("select_drain");

        // Right in REPEAT, async reset lands while right_out is high
        n = cyc;
        btn_right_in = 1'b1;
        t0 = n + 6;
        push(t0 + 1, K_RIGHT);
        push(t0 + 21, K_RIGHT);
        push(t0 + 26, K_RIGHT);
        at_cycle(t0 + 30);
        @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        checks++;
        assert ({left_out, right_out, select_out, held_out} === 5'b0) else begin
            errors++;
            $error("FAIL async_reset: outputs=%b, required 00000", {left_out, right_out, select_out, held_out});
        end
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        r = cyc;
        push(r + 7, K_RIGHT);
        push(r + 27, K_RIGHT);
        at_cycle(r + 5);
        check_held(2'b00, "post_reset_redebounce");
        at_cycle(r + 22);
        btn_right_in = 1'b0;
        at_cycle(r + 40);
        check_drained("post_reset_drain");
        check_held(2'b00, "post_reset_released");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
